// File: rtl/product_arbiter.sv
// Round-robin arbiter sharing one product datapath between R requesters; a grant is
// held for the whole transaction. Optional fixed priority for requester 0: PRODUCT_ARBITER_PRIORITY_EN.
module product_arbiter #(
    parameter int R = 4,
    parameter int N = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [R-1:0]                req_argument_valid,
    input  logic [R-1:0][N-1:0][7:0]    req_argument_data,
    output logic [R-1:0]                req_argument_ready,
    input  logic [R-1:0]                req_train,
    output logic [R-1:0]                req_result_valid,
    output logic [15:0]                 req_result_data,
    input  logic [R-1:0]                req_result_ready,
    input  logic [R-1:0]                req_error_valid,
    input  logic [R-1:0][15:0]          req_error_data,
    output logic [R-1:0]                req_error_ready,
    output logic [R-1:0]                req_propagate_valid,
    output logic [N-1:0][15:0]          req_propagate_data,
    input  logic [R-1:0]                req_propagate_ready,
    output logic                        train,
    output logic                        argument_valid,
    output logic [N-1:0][7:0]           argument_data,
    input  logic                        argument_ready,
    input  logic                        result_valid,
    input  logic [15:0]                 result_data,
    output logic                        result_ready,
    output logic                        error_valid,
    output logic [15:0]                 error_data,
    input  logic                        error_ready,
    input  logic                        propagate_valid,
    input  logic [N-1:0][15:0]          propagate_data,
    output logic                        propagate_ready,
    output logic [$clog2(R)-1:0]        grant,
    output logic                        busy,
    output logic [2:0]                  state
);
    localparam int GW = $clog2(R);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARG  = 3'd1,
        S_RES  = 3'd2,
        S_ERR  = 3'd3,
        S_PRP  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_q, rr_d;
    logic          train_q, train_d;
    logic [GW-1:0] pick;
    logic          found;
    logic [GW-1:0] rr_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            train_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            train_q <= train_d;
        end
    end

    // First valid requester at or above the rr pointer, wrapping around.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < R; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= R) idx = idx - R;
            if (!found && req_argument_valid[idx]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
`ifdef PRODUCT_ARBITER_PRIORITY_EN
        if (req_argument_valid[0]) begin
            found = 1'b1;
            pick  = '0;
        end
`endif
    end

    always_comb begin
        rr_next = (grant_q == GW'(R - 1)) ? '0 : grant_q + 1'b1;
`ifdef PRODUCT_ARBITER_PRIORITY_EN
        // Requester-0 transactions leave the rotation of the others untouched.
        if (grant_q == '0) rr_next = rr_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        train_d = train_q;
        case (state_q)
            S_IDLE: if (found) begin
                grant_d = pick;
                train_d = req_train[pick];
                state_d = S_ARG;
            end
            S_ARG: if (argument_valid && argument_ready) state_d = S_RES;
            S_RES: if (result_valid && result_ready) begin
                if (train_q) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_IDLE;
                    rr_d    = rr_next;
                end
            end
            S_ERR: if (error_valid && error_ready) state_d = S_PRP;
            S_PRP: if (propagate_valid && propagate_ready) begin
                state_d = S_IDLE;
                rr_d    = rr_next;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Channel routing: every valid/ready is gated by state, data buses pass straight through.
    always_comb begin
        req_argument_ready  = '0;
        req_result_valid    = '0;
        req_error_ready     = '0;
        req_propagate_valid = '0;
        argument_valid      = 1'b0;
        result_ready        = 1'b0;
        error_valid         = 1'b0;
        propagate_ready     = 1'b0;
        argument_data       = req_argument_data[grant_q];
        error_data          = req_error_data[grant_q];
        req_result_data     = result_data;
        req_propagate_data  = propagate_data;
        case (state_q)
            S_ARG: begin
                argument_valid              = req_argument_valid[grant_q];
                req_argument_ready[grant_q] = argument_ready;
            end
            S_RES: begin
                req_result_valid[grant_q] = result_valid;
                result_ready              = req_result_ready[grant_q];
            end
            S_ERR: begin
                error_valid              = req_error_valid[grant_q];
                req_error_ready[grant_q] = error_ready;
            end
            S_PRP: begin
                req_propagate_valid[grant_q] = propagate_valid;
                propagate_ready              = req_propagate_ready[grant_q];
            end
            default: ;
        endcase
    end

    assign grant = grant_q;
    assign train = train_q;
    assign busy  = (state_q != S_IDLE);
    assign state = state_q;

endmodule

// File: doc/product_arbiter.md
Name: product_arbiter

Overview:
- Shares one product datapath (single-neuron inner-product/backprop unit) between R independent requesters.
- Round-robin grant, locked for the full transaction: argument -> result -> (if training) error -> propagate.
- Forward and backward channels are routed to and from the granted requester only.
- Sits between layer-level sequencers (upstream) and one product instance (downstream).

Parameters:
- R, 4, number of requesters (R >= 2)
- N, 2, argument vector length; must match the attached product datapath

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_argument_valid  in  R  per-requester argument valid
- req_argument_data  in  R x N x 8  per-requester argument vectors
- req_argument_ready  out  R  per-requester argument ready
- req_train  in  R  per-requester training flag, sampled at grant
- req_result_valid  out  R  result valid, granted requester only
- req_result_data  out  16  shared result bus
- req_result_ready  in  R  per-requester result ready
- req_error_valid  in  R  per-requester error valid
- req_error_data  in  R x 16  per-requester error
- req_error_ready  out  R  error ready, granted requester only
- req_propagate_valid  out  R  propagate valid, granted requester only
- req_propagate_data  out  N x 16  shared propagate bus
- req_propagate_ready  in  R  per-requester propagate ready
- train  out  1  latched training flag to datapath
- argument_valid/argument_data/argument_ready  out/out/in  1/N x 8/1  datapath argument channel
- result_valid/result_data/result_ready  in/in/out  1/16/1  datapath result channel
- error_valid/error_data/error_ready  out/out/in  1/16/1  datapath error channel
- propagate_valid/propagate_data/propagate_ready  in/in/out  1/N x 16/1  datapath propagate channel
- grant  out  clog2(R)  index of current owner
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, reset==0) gives: state IDLE, grant 0, rr pointer 0, train 0, busy 0. All per-requester and datapath valids/readies deassert combinationally from state, so they read 0 during reset.
- States: IDLE, ARG, RES, ERR, PRP.
- IDLE: if any req_argument_valid is set, pick the first set bit searching from the rr pointer upward with wrap-around. Register that index in grant, latch req_train[grant] into train, go to ARG. With no requests, stay in IDLE. Grant decision costs 1 cycle.
- ARG: argument_valid = req_argument_valid[grant]; argument_data = req_argument_data[grant]; req_argument_ready[grant] = argument_ready; other req_argument_ready bits are 0. On handshake go to RES. If the owner drops valid, keep waiting; the grant is never revoked.
- RES: req_result_valid[grant] = result_valid; result_ready = req_result_ready[grant]; req_result_data = result_data. On handshake: go to ERR if train==1, else return to IDLE.
- ERR: error channel routed as in ARG, from the granted requester. On handshake go to PRP.
- PRP: propagate channel routed to the granted requester. On handshake return to IDLE.
- Returning to IDLE sets rr pointer = grant+1 mod R.
- Routing is purely combinational: zero added latency per channel and no buffering.
- Non-granted requesters see every valid and ready at 0. Their inputs are ignored.
- A new argument may be presented from IDLE while the datapath is still updating weights. The datapath holds argument_ready low, so the arbiter simply waits in ARG.
- Requests arriving in the same cycle as a transaction ends are considered on the next IDLE cycle.
- Reset asserted mid-transaction aborts the transaction. The datapath must be reset together with the arbiter (system integration requirement).
- req_train changes after grant have no effect until the next grant.

Optional Feature:
- PRODUCT_ARBITER_PRIORITY_EN. When defined, requester 0 has fixed highest priority in IDLE: if req_argument_valid[0] is set it wins regardless of the rr pointer. Otherwise round-robin applies to the remaining requesters, and the rr pointer does not advance after requester-0 transactions.
- When undefined, pure round-robin applies to all R requesters.

Test Plan:
- Single requester 2, train=0, argument {8'h40,8'h20}; datapath returns 16'h0123 -> req_result_valid=4'b0100, req_result_data=16'h0123, then IDLE. error_ready and propagate_valid are never seen.
- Requesters 0..3 all valid continuously with train=0 -> grants in order 0,1,2,3,0; each grant holds until its result handshake.
- Requester 1 with train=1, error 16'hFF00, datapath propagate {16'h0010,16'h0020} -> error_data=16'hFF00 forwarded; req_propagate_valid[1] asserted with that data; grant released only after req_propagate_ready[1].
- Grant held under backpressure: requester 3 holds req_result_ready low for 10 cycles while requester 0 requests -> grant stays 3 and requester 0 sees no ready.
- Async reset pulsed low while in RES -> busy=0 and all valids 0 immediately, without waiting for a clock edge; after release the first grant goes to the lowest-index valid requester.
- PRODUCT_ARBITER_PRIORITY_EN defined, requesters 0 and 2 both valid repeatedly -> requester 0 wins every arbitration.
